// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port-B arbiter bundle: pixel write requests, fill control and the RAM port.
// slave = arbiter side, master = requester/RAM side.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              px_valid;
    logic              px_ready;
    logic [ADDR_W-1:0] px_addr;
    logic [1:0]        px_data;
    logic              clr_start;
    logic [3:0]        clr_value;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_wdata;
    logic [3:0]        ram_rdata;

    modport slave (
        input  px_valid, px_addr, px_data, clr_start, clr_value, ram_rdata,
        output px_ready, clr_busy, clr_done, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output px_valid, px_addr, px_data, clr_start, clr_value, ram_rdata,
        input  px_ready, clr_busy, clr_done, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer port-B arbiter: pixel read-modify-write blends (READ then WRITE, one pixel per 2 cycles)
// take priority over a background fill; px_ready drops while a held pixel waits for its WRITE.
module fb_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int FB_DEPTH = 23040
) (
    input  logic             clk,
    input  logic             rst_n,
    fb_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic              slot_vld_q, slot_vld_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [1:0]        slot_data_q, slot_data_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;
    logic [3:0]        clr_val_q, clr_val_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [3:0]        ram_wdata_q, ram_wdata_d;

    logic              px_ready;
    logic              xfer;
    logic [4:0]        blend_sum;
    logic [3:0]        blend;

    assign px_ready  = !slot_vld_q || (state_q == ST_WRITE);
    assign xfer      = bus.px_valid && px_ready;
    // Worst case 15 + 5*3 = 30 fits in 5 bits, so the halved result never exceeds 15.
    assign blend_sum = {1'b0, bus.ram_rdata} + ({3'b000, slot_data_q} * 5'd5);
    assign blend     = 4'(blend_sum >> 1);

    assign bus.px_ready  = px_ready;
    assign bus.clr_busy  = clr_busy_q;
    assign bus.clr_done  = clr_done_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = (state_q == ST_WRITE) ? blend : ram_wdata_q;

    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        clr_busy_d  = clr_busy_q;
        clr_done_d  = 1'b0;
        clr_val_d   = clr_val_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        ram_addr_d  = '0;
        ram_we_d    = 1'b0;
        ram_wdata_d = 4'd0;

        if (xfer) begin
            slot_vld_d  = 1'b1;
            slot_addr_d = bus.px_addr;
            slot_data_d = bus.px_data;
        end else if (state_q == ST_WRITE) begin
            slot_vld_d = 1'b0;
        end

        // A CLEAR cycle always carries the write of cnt_q; the counter only moves here.
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                cnt_d      = '0;
                clr_busy_d = 1'b0;
                clr_done_d = 1'b1;
            end
        end

        if (bus.clr_start) begin
            clr_val_d  = bus.clr_value;
            cnt_d      = '0;
            clr_busy_d = 1'b1;
            clr_done_d = 1'b0;
        end

        case (state_q)
            ST_READ:  state_d = ST_WRITE;
            ST_IDLE, ST_WRITE, ST_CLEAR: begin
                if (xfer || (slot_vld_q && state_q != ST_WRITE)) begin
                    state_d = ST_READ;
                end else if (clr_busy_d) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        // Port-B outputs are registered, so they are derived from the state being entered.
        case (state_d)
            ST_READ: begin
                ram_addr_d = slot_addr_d;
            end
            ST_WRITE: begin
                ram_addr_d = slot_addr_d;
                ram_we_d   = 1'b1;
            end
            ST_CLEAR: begin
                ram_addr_d  = cnt_d;
                ram_we_d    = 1'b1;
                ram_wdata_d = clr_val_d;
            end
            default: begin
                ram_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_vld_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= 2'd0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            clr_val_q   <= 4'd0;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            clr_busy_q  <= clr_busy_d;
            clr_done_q  <= clr_done_d;
            clr_val_q   <= clr_val_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter with a small framebuffer (8-word fill, 128-word RAM).
module tb_fb_port_arbiter;
    localparam int ADDR_W   = 7;
    localparam int FB_DEPTH = 8;
    localparam int MEM_N    = 1 << ADDR_W;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int exp_mem [MEM_N];
    int pq_addr [$];
    int pq_data [$];

    logic [3:0]        mem [MEM_N];
    logic              mem_zero;
    logic              bk_we;
    logic [ADDR_W-1:0] bk_addr;
    logic [3:0]        bk_dat;

    fb_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    fb_port_arbiter #(.ADDR_W(ADDR_W), .FB_DEPTH(FB_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: rdata shows mem[addr] one cycle after addr is sampled.
    always @(posedge clk) begin
        if (mem_zero) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= 4'd0;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            if (bk_we) mem[bk_addr] <= bk_dat;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    function automatic int blend_f(input int old_v, input int shade);
        return (old_v + 5 * shade) / 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_zero = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_dat = 4'd0;
        bus.px_valid = 1'b0; bus.px_addr = '0; bus.px_data = 2'd0;
        bus.clr_start = 1'b0; bus.clr_value = 4'd0;
        for (int i = 0; i < MEM_N; i++) exp_mem[i] = 0;
        step(); step();
        checks++;
        if ({bus.px_ready, bus.clr_busy, bus.clr_done, bus.ram_we} !== 4'b1000 ||
            bus.ram_addr !== 7'd0 || bus.ram_wdata !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold rdy/busy/done/we=%b addr=%0d wdata=%0d required 1000 0 0",
                     {bus.px_ready, bus.clr_busy, bus.clr_done, bus.ram_we}, bus.ram_addr, bus.ram_wdata);
        end
        rst_n = 1'b1; mem_zero = 1'b0;
        step();
        checks++;
        if ({bus.px_ready, bus.clr_busy, bus.clr_done, bus.ram_we} !== 4'b1000 ||
            bus.ram_addr !== 7'd0 || bus.ram_wdata !== 4'd0) begin
            errors++;
            $display("FAIL reset_release rdy/busy/done/we=%b addr=%0d wdata=%0d required 1000 0 0",
                     {bus.px_ready, bus.clr_busy, bus.clr_done, bus.ram_we}, bus.ram_addr, bus.ram_wdata);
        end
    endtask

    task automatic test_single_pixel();
        bk_we = 1'b1; bk_addr = 7'd100; bk_dat = 4'd7;
        step();
        bk_we = 1'b0;
        exp_mem[100] = 7;
        bus.px_valid = 1'b1; bus.px_addr = 7'd100; bus.px_data = 2'd3;
        checks++;
        if (bus.px_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready got %b required 1", bus.px_ready);
        end
        step();
        bus.px_valid = 1'b0;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 7'd100 || bus.px_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_read we=%b addr=%0d rdy=%b required 0 100 0", bus.ram_we, bus.ram_addr, bus.px_ready);
        end
        step();
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 7'd100 || bus.ram_wdata !== 4'd11) begin
            errors++;
            $display("FAIL single_write we=%b addr=%0d wdata=%0d required 1 100 11", bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        exp_mem[100] = 11;
        step();
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 7'd0 || bus.px_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_idle we=%b addr=%0d rdy=%b required 0 0 1", bus.ram_we, bus.ram_addr, bus.px_ready);
        end
    endtask

    task automatic test_back_to_back();
        int sent, we_cnt, last_acc, a, d, e;
        bit acc;
        sent = 0; we_cnt = 0; last_acc = -1; acc = 1'b0;
        bus.px_valid = 1'b1; bus.px_addr = 7'($urandom_range(127, 8)); bus.px_data = 2'($urandom_range(3, 0));
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.ram_we) begin
                we_cnt++;
                checks++;
                if (pq_addr.size() == 0) begin
                    errors++; $display("FAIL b2b_write unexpected write addr=%0d", bus.ram_addr);
                end else begin
                    a = pq_addr.pop_front(); d = pq_data.pop_front();
                    e = blend_f(exp_mem[a], d); exp_mem[a] = e;
                    if (int'(bus.ram_addr) !== a || int'(bus.ram_wdata) !== e) begin
                        errors++;
                        $display("FAIL b2b_write addr=%0d wdata=%0d required %0d %0d", bus.ram_addr, bus.ram_wdata, a, e);
                    end
                end
            end
            if (acc) begin
                acc = 1'b0;
                if (sent < 4) begin
                    bus.px_addr = 7'($urandom_range(127, 8)); bus.px_data = 2'($urandom_range(3, 0));
                end else begin
                    bus.px_valid = 1'b0;
                end
            end
            if (bus.px_valid && bus.px_ready) begin
                pq_addr.push_back(int'(bus.px_addr)); pq_data.push_back(int'(bus.px_data));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 2) begin
                        errors++; $display("FAIL b2b_spacing gap=%0d required 2", cyc - last_acc);
                    end
                end
                last_acc = cyc; sent++; acc = 1'b1;
            end
            step();
        end
        bus.px_valid = 1'b0;
        checks++;
        if (sent != 4 || we_cnt != 4) begin
            errors++; $display("FAIL b2b_counts accepted=%0d writes=%0d required 4 4", sent, we_cnt);
        end
    endtask

    task automatic test_clear();
        bus.clr_value = 4'hF; bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        for (int k = 0; k < FB_DEPTH; k++) begin
            checks++;
            if ({bus.clr_busy, bus.clr_done, bus.ram_we} !== 3'b101 || int'(bus.ram_addr) !== k || bus.ram_wdata !== 4'hF) begin
                errors++;
                $display("FAIL clear_write busy/done/we=%b addr=%0d wdata=%0d required 101 %0d 15",
                         {bus.clr_busy, bus.clr_done, bus.ram_we}, bus.ram_addr, bus.ram_wdata, k);
            end
            step();
        end
        checks++;
        if ({bus.clr_busy, bus.clr_done, bus.ram_we} !== 3'b010) begin
            errors++; $display("FAIL clear_done busy/done/we=%b required 010", {bus.clr_busy, bus.clr_done, bus.ram_we});
        end
        step();
        checks++;
        if ({bus.clr_busy, bus.clr_done, bus.ram_we} !== 3'b000) begin
            errors++; $display("FAIL clear_after busy/done/we=%b required 000", {bus.clr_busy, bus.clr_done, bus.ram_we});
        end
    endtask

    task automatic test_pixel_mid_fill();
        int nc, done_cnt, pix_wr, a, d, e;
        bit sent, drop, expect_read;
        nc = 0; done_cnt = 0; pix_wr = 0; sent = 1'b0; drop = 1'b0; expect_read = 1'b0;
        bus.clr_value = 4'd5; bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (expect_read) begin
                expect_read = 1'b0;
                checks++;
                if (bus.ram_we !== 1'b0 || bus.ram_addr !== 7'd90) begin
                    errors++; $display("FAIL midfill_read we=%b addr=%0d required 0 90", bus.ram_we, bus.ram_addr);
                end
            end
            if (bus.clr_done) done_cnt++;
            if (bus.ram_we) begin
                checks++;
                if (int'(bus.ram_addr) < FB_DEPTH) begin
                    if (int'(bus.ram_addr) !== nc || bus.ram_wdata !== 4'd5) begin
                        errors++; $display("FAIL midfill_clear addr=%0d wdata=%0d required %0d 5", bus.ram_addr, bus.ram_wdata, nc);
                    end
                    nc++;
                end else if (pq_addr.size() == 0) begin
                    errors++; $display("FAIL midfill_pixel unexpected write addr=%0d", bus.ram_addr);
                end else begin
                    a = pq_addr.pop_front(); d = pq_data.pop_front();
                    e = blend_f(exp_mem[a], d); exp_mem[a] = e; pix_wr++;
                    if (int'(bus.ram_addr) !== a || int'(bus.ram_wdata) !== e) begin
                        errors++; $display("FAIL midfill_pixel addr=%0d wdata=%0d required %0d %0d", bus.ram_addr, bus.ram_wdata, a, e);
                    end
                end
            end
            if (drop) begin bus.px_valid = 1'b0; drop = 1'b0; end
            if (!sent && bus.ram_we && bus.ram_addr == 7'd2) begin
                bus.px_valid = 1'b1; bus.px_addr = 7'd90; bus.px_data = 2'd2; sent = 1'b1;
            end
            if (bus.px_valid && bus.px_ready) begin
                pq_addr.push_back(90); pq_data.push_back(2); drop = 1'b1; expect_read = 1'b1;
            end
            step();
        end
        bus.px_valid = 1'b0;
        checks++;
        if (nc != FB_DEPTH || done_cnt != 1 || pix_wr != 1 || bus.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL midfill_summary clears=%0d dones=%0d pixels=%0d busy=%b required 8 1 1 0", nc, done_cnt, pix_wr, bus.clr_busy);
        end
    endtask

    task automatic test_restart();
        int nc, cv, done_cnt;
        bit restarted, drop;
        nc = 0; cv = 15; done_cnt = 0; restarted = 1'b0; drop = 1'b0;
        bus.clr_value = 4'hF; bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (drop) begin bus.clr_start = 1'b0; drop = 1'b0; end
            if (bus.clr_done) done_cnt++;
            if (bus.ram_we) begin
                checks++;
                if (int'(bus.ram_addr) !== nc || int'(bus.ram_wdata) !== cv) begin
                    errors++; $display("FAIL restart_write addr=%0d wdata=%0d required %0d %0d", bus.ram_addr, bus.ram_wdata, nc, cv);
                end
                nc++;
                if (!restarted && bus.ram_addr == 7'd5) begin
                    bus.clr_start = 1'b1; bus.clr_value = 4'h2;
                    restarted = 1'b1; drop = 1'b1; nc = 0; cv = 2;
                end
            end
            step();
        end
        checks++;
        if (!restarted || nc != FB_DEPTH || done_cnt != 1) begin
            errors++; $display("FAIL restart_summary restarted=%0d clears=%0d dones=%0d required 1 8 1", restarted, nc, done_cnt);
        end
    endtask

    task automatic test_collision();
        int e;
        bus.px_valid = 1'b1; bus.px_addr = 7'd50; bus.px_data = 2'd1;
        bus.clr_value = 4'd9; bus.clr_start = 1'b1;
        step();
        bus.px_valid = 1'b0; bus.clr_start = 1'b0;
        checks++;
        if (bus.clr_busy !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 7'd50) begin
            errors++; $display("FAIL collide_read busy=%b we=%b addr=%0d required 1 0 50", bus.clr_busy, bus.ram_we, bus.ram_addr);
        end
        step();
        e = blend_f(exp_mem[50], 1); exp_mem[50] = e;
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 7'd50 || int'(bus.ram_wdata) !== e) begin
            errors++; $display("FAIL collide_write we=%b addr=%0d wdata=%0d required 1 50 %0d", bus.ram_we, bus.ram_addr, bus.ram_wdata, e);
        end
        for (int k = 0; k < FB_DEPTH; k++) begin
            step();
            checks++;
            if (bus.ram_we !== 1'b1 || int'(bus.ram_addr) !== k || bus.ram_wdata !== 4'd9) begin
                errors++; $display("FAIL collide_clear we=%b addr=%0d wdata=%0d required 1 %0d 9", bus.ram_we, bus.ram_addr, bus.ram_wdata, k);
            end
        end
        step();
        checks++;
        if (bus.clr_done !== 1'b1 || bus.clr_busy !== 1'b0) begin
            errors++; $display("FAIL collide_done done=%b busy=%b required 1 0", bus.clr_done, bus.clr_busy);
        end
        step();
    endtask

    task automatic test_reset_mid_fill();
        int we_cnt;
        we_cnt = 0;
        bus.clr_value = 4'd3; bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        step(); step();
        checks++;
        if (bus.ram_we !== 1'b1 || bus.clr_busy !== 1'b1) begin
            errors++; $display("FAIL rstfill_pre we=%b busy=%b required 1 1", bus.ram_we, bus.clr_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.px_ready, bus.clr_busy, bus.clr_done, bus.ram_we} !== 4'b1000 ||
            bus.ram_addr !== 7'd0 || bus.ram_wdata !== 4'd0) begin
            errors++;
            $display("FAIL rstfill_async rdy/busy/done/we=%b addr=%0d wdata=%0d required 1000 0 0",
                     {bus.px_ready, bus.clr_busy, bus.clr_done, bus.ram_we}, bus.ram_addr, bus.ram_wdata);
        end
        step();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (bus.ram_we || bus.clr_busy) we_cnt++;
        end
        checks++;
        if (we_cnt != 0) begin
            errors++; $display("FAIL rstfill_quiet active_cycles=%0d required 0", we_cnt);
        end
    endtask

    task automatic test_random();
        int n_pix, sent, nc, cv, done_cnt, pix_wr, start_cyc, gap, a, d, e, bad;
        bit acc, started, clr_drop, exp_rdy, finished;
        for (int r = 0; r < 6; r++) begin
            n_pix = $urandom_range(12, 4); sent = 0; nc = 0; cv = $urandom_range(15, 0);
            done_cnt = 0; pix_wr = 0; start_cyc = $urandom_range(15, 0); gap = $urandom_range(3, 0);
            acc = 1'b0; started = 1'b0; clr_drop = 1'b0; finished = 1'b0;
            for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
                exp_rdy = (pq_addr.size() == 0) || (bus.ram_we && int'(bus.ram_addr) >= FB_DEPTH);
                checks++;
                if (bus.px_ready !== exp_rdy) begin
                    errors++; $display("FAIL rand_ready round=%0d cyc=%0d got %b required %b", r, cyc, bus.px_ready, exp_rdy);
                end
                if (bus.clr_done) begin
                    done_cnt++;
                    checks++;
                    if (nc != FB_DEPTH) begin
                        errors++; $display("FAIL rand_done_early round=%0d clears=%0d required %0d", r, nc, FB_DEPTH);
                    end
                end
                if (bus.ram_we) begin
                    checks++;
                    if (int'(bus.ram_addr) < FB_DEPTH) begin
                        if (!started || int'(bus.ram_addr) !== nc || int'(bus.ram_wdata) !== cv) begin
                            errors++; $display("FAIL rand_clear round=%0d addr=%0d wdata=%0d required %0d %0d", r, bus.ram_addr, bus.ram_wdata, nc, cv);
                        end
                        nc++;
                    end else if (pq_addr.size() == 0) begin
                        errors++; $display("FAIL rand_pixel round=%0d unexpected write addr=%0d", r, bus.ram_addr);
                    end else begin
                        a = pq_addr.pop_front(); d = pq_data.pop_front();
                        e = blend_f(exp_mem[a], d); exp_mem[a] = e; pix_wr++;
                        if (int'(bus.ram_addr) !== a || int'(bus.ram_wdata) !== e) begin
                            errors++; $display("FAIL rand_pixel round=%0d addr=%0d wdata=%0d required %0d %0d", r, bus.ram_addr, bus.ram_wdata, a, e);
                        end
                    end
                end
                if (clr_drop) begin bus.clr_start = 1'b0; clr_drop = 1'b0; end
                if (acc) begin bus.px_valid = 1'b0; acc = 1'b0; gap = $urandom_range(3, 0); end
                if (!bus.px_valid && sent < n_pix) begin
                    if (gap == 0) begin
                        bus.px_valid = 1'b1;
                        bus.px_addr = 7'($urandom_range(127, FB_DEPTH));
                        bus.px_data = 2'($urandom_range(3, 0));
                    end else begin
                        gap--;
                    end
                end
                if (!started && cyc == start_cyc) begin
                    bus.clr_start = 1'b1; bus.clr_value = 4'(cv); started = 1'b1; clr_drop = 1'b1;
                end
                if (bus.px_valid && bus.px_ready) begin
                    pq_addr.push_back(int'(bus.px_addr)); pq_data.push_back(int'(bus.px_data));
                    sent++; acc = 1'b1;
                end
                finished = started && !acc && !clr_drop && done_cnt > 0 && sent == n_pix && pq_addr.size() == 0;
                if (!finished) step();
            end
            bus.px_valid = 1'b0; bus.clr_start = 1'b0;
            step();
            checks++;
            if (!finished || done_cnt != 1 || nc != FB_DEPTH || pix_wr != n_pix) begin
                errors++;
                $display("FAIL rand_summary round=%0d finished=%0d dones=%0d clears=%0d pixels=%0d required 1 1 %0d %0d",
                         r, finished, done_cnt, nc, pix_wr, FB_DEPTH, n_pix);
            end
            bad = 0;
            for (int i = 0; i < MEM_N; i++) begin
                if (i < FB_DEPTH) begin
                    if (int'(mem[i]) != cv) bad++;
                end else if (int'(mem[i]) != exp_mem[i]) begin
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand_memory round=%0d wrong_words=%0d required 0", r, bad);
            end
            pq_addr.delete(); pq_data.delete();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_clear();
        test_pixel_mid_fill();
        test_restart();
        test_collision();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, framebuffer address width.
REQ-002 SHALL have parameter FB_DEPTH, default 23040 (160x144), number of framebuffer words cleared.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port px_valid, input, 1, pixel write request.
REQ-006 SHALL have port px_ready, output, 1, pixel request can be accepted.
REQ-007 SHALL have port px_addr, input, ADDR_W, pixel address.
REQ-008 SHALL have port px_data, input, 2, pixel shade (0..3).
REQ-009 SHALL have port clr_start, input, 1, one-cycle pulse that starts a framebuffer fill.
REQ-010 SHALL have port clr_value, input, 4, fill value, sampled with clr_start.
REQ-011 SHALL have port clr_busy, output, 1, fill in progress.
REQ-012 SHALL have port clr_done, output, 1, one-cycle pulse when a fill completes.
REQ-013 SHALL have port ram_addr, output, ADDR_W, framebuffer port-B address.
REQ-014 SHALL have port ram_we, output, 1, framebuffer port-B write enable.
REQ-015 SHALL have port ram_wdata, output, 4, framebuffer port-B write data.
REQ-016 SHALL have port ram_rdata, input, 4; holds mem[addr] one cycle after the RAM samples addr.

Function
REQ-017 SHALL hold a one-entry pixel slot (addr, data); a transfer occurs on an edge where px_valid and px_ready are both high.
REQ-018 SHALL drive px_ready = slot empty OR state==WRITE, so back-to-back pixels are accepted every 2 cycles.
REQ-019 SHALL implement states IDLE, READ, WRITE and CLEAR.
REQ-020 Pixel sequence: in the cycle after a transfer, enter READ: ram_addr=slot addr, ram_we=0. Next cycle enter WRITE: ram_addr=slot addr, ram_we=1, ram_wdata=blend. The slot frees at the end of WRITE.
REQ-021 SHALL compute the blend combinationally in WRITE as (ram_rdata + 5*data)>>1 with a 5-bit intermediate. The result is always 0..15; no saturation is needed.
REQ-022 From WRITE: go to READ if a new transfer occurred in that cycle; else to CLEAR if clr_busy; else to IDLE.
REQ-023 clr_start in any state: latch clr_value, set clear counter to 0, assert clr_busy next cycle. clr_start while busy restarts the fill from 0 with the new value.
REQ-024 In CLEAR with the slot empty: ram_addr=counter, ram_we=1, ram_wdata=latched value; counter increments by 1 per write.
REQ-025 Pixels have priority: a full slot in CLEAR or IDLE moves to READ next cycle. The clear counter holds while pixels are serviced, and CLEAR resumes at the held count.
REQ-026 After the write of address FB_DEPTH-1: clear clr_busy and pulse clr_done for exactly 1 cycle, then go to IDLE or READ.
REQ-027 Simultaneous clr_start and pixel transfer: the pixel is serviced first, and the fill begins after its WRITE.
REQ-028 In IDLE: ram_addr=0, ram_we=0, ram_wdata=0.
REQ-029 ram_addr and ram_we SHALL be registered; ram_wdata is registered except for the WRITE blend.

Reset
REQ-030 While rst_n is low: state=IDLE, slot empty, px_ready=1, clr_busy=0, clr_done=0, ram_we=0, ram_addr=0, ram_wdata=0, counter=0.
REQ-031 Reset asserted mid-operation SHALL abort any pixel or fill with no further ram_we pulse; the fill does not resume after reset.

Verification
REQ-032 Pixel addr=100, data=3, ram_rdata=7 -> READ addr 100, then WRITE addr 100 we=1 wdata=11.
REQ-033 px_valid held high with 4 pixels -> accepted 2 cycles apart; exactly one we pulse per pixel; wdata matches the blend for each.
REQ-034 clr_start value=0xF, FB_DEPTH=8 -> 8 consecutive writes to addr 0..7 data 0xF, clr_busy high 8 cycles, then a single clr_done pulse.
REQ-035 Pixel arrives mid-fill at counter=3 -> READ/WRITE for the pixel inserted, then the fill resumes at addr 3; no address skipped or repeated; clr_done after addr 7.
REQ-036 clr_start again at counter=5 with value 0x2 -> fill restarts at addr 0 with data 0x2; only one clr_done.
REQ-037 rst_n low during a WRITE of a fill -> all outputs at reset values immediately; no writes after release until a new request.
